chime_sequencer: RTL and testbench
==================================

Name: chime_sequencer

Overview:
- Upstream control stage for the PWM tone generator.
- On a trigger from the clock core (hour rollover or alarm match), steps through a fixed melody table and drives a per-note half-period count and a tone enable to the tone generator.
- Owns note timing, rests, repeat count and abort; the tone generator only toggles its output at the given half-period.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz; sets the ms prescale (CLK_FREQ/1000 cycles per ms).
- NUM_NOTES, 17, melody table length (1..32).
- DUR_W, 16, width of a note duration in ms.
- HP_W, 26, width of half_period.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle trigger pulse
- repeat_cnt  in  3  extra repeats, sampled at accepted start; melody plays repeat_cnt+1 times
- abort  in  1  level or pulse; stops playback immediately
- half_period  out  HP_W  clocks per half-cycle of the current note; 0 during a rest
- tone_en  out  1  tone generator enable
- note_idx  out  5  index of the current note
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (async, reset_n=0): state IDLE; half_period=0, tone_en=0, note_idx=0, busy=0, done=0; prescaler, duration counter and repeat counter cleared.
- FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - start=1 and abort=0 -> LOAD next cycle; latch repeat_cnt; note_idx=0; busy=1.
- LOAD (exactly 1 cycle):
  - Read table[note_idx] = {note code, duration ms}.
  - Register half_period = package constant for that code.
  - tone_en = (code != REST).
  - dur_cnt = max(duration, 1); clear prescaler. Go to PLAY.
- PLAY:
  - The prescaler emits ms_tick every CLK_FREQ/1000 cycles.
  - dur_cnt decrements on each ms_tick.
  - On the tick where dur_cnt==1, the note ends:
    - not last note -> note_idx+1, LOAD;
    - last note with repeats remaining -> decrement repeats, note_idx=0, LOAD;
    - otherwise -> DONE.
- DONE (1 cycle): done=1, tone_en=0, half_period=0, busy=0 -> IDLE.
- Note timing: a note of D ms occupies exactly 1 + D*(CLK_FREQ/1000) cycles (LOAD plus PLAY). Outputs are stable for that whole span.
- abort=1 in any non-IDLE state -> IDLE next cycle: tone_en=0, half_period=0, busy=0, no done pulse.
- abort and start in the same cycle in IDLE: abort wins; the block stays IDLE.
- start while busy: ignored; it neither restarts nor queues.
- Arithmetic: half-period constants are CLK_FREQ/(2*f), truncated, computed at elaboration; no runtime division. note_idx wraps only via the last-note rule, never modulo.
- Out-of-range note code reads as REST.

Optional Feature:
- Macro CHIME_GAP_EN.
- When defined:
  - Adds a GAP state between consecutive notes, including across a repeat boundary, but not after the final note.
  - GAP lasts GAP_MS (package constant, 20) ms with tone_en=0 and half_period held.
  - Then LOAD of the next note.
  - abort in GAP behaves as in PLAY.
- When undefined: no GAP state exists; notes are back-to-back exactly as above.

Decomposition:
- Shared package chime_pkg holds:
  - the note-code enum (REST, E2, FS2, C4..B4);
  - half-period function/constants;
  - the melody table as a constant array of {code, duration};
  - GAP_MS and the state encoding.
- One sub-module, ms_tick_gen:
  - prescaler with sync clear input;
  - one-cycle tick output every CLK_FREQ/1000 cycles.

Test Plan (CLK_FREQ=10000, so 10 cycles/ms; table overridden to 3 notes {A4,2ms},{REST,1ms},{C4,0ms}):
- Reset held then released -> all outputs 0, busy=0. Assert reset_n low mid-PLAY -> outputs 0 asynchronously.
- start, repeat_cnt=0 -> note 0 half_period=11, tone_en=1 for 21 cycles; note 1 tone_en=0, half_period=0 for 11 cycles; note 2 (duration 0 treated as 1 ms) half_period=19 for 11 cycles; then done pulse one cycle; busy falls the same cycle.
- start, repeat_cnt=2 -> note_idx sequence 0,1,2 three times; one done pulse after 129 cycles of busy.
- abort asserted at cycle 5 of note 0 -> next cycle tone_en=0, busy=0, no done. A second start pulse while busy -> no effect on timing.
- start and abort in the same cycle from IDLE -> busy stays 0.
- With CHIME_GAP_EN -> 20 ms (200 cycles) tone_en=0 between notes; no gap before done; total 1+... verified against 2*200 extra cycles per pass.

Source files
------------

// File: rtl/chime_pkg.sv
// Shared definitions for the chime sequencer: note codes, half-period math, default melody, states.
// CHIME_GAP_EN adds the inter-note GAP state to the state encoding.
package chime_pkg;

   localparam int MAX_NOTES = 32;
   localparam int NOTE_W    = 5;
   localparam int TBL_DUR_W = 16;
   localparam int GAP_MS    = 20;
   localparam int NUM_CODES = 15;

   typedef enum logic [NOTE_W-1:0] {
      REST = 5'd0, E2, FS2, C4, CS4, D4, DS4, E4, F4, FS4, G4, GS4, A4, AS4, B4
   } note_e;

   typedef struct packed {
      note_e                code;
      logic [TBL_DUR_W-1:0] dur_ms;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Entry i of the melody lives at bits [i*ENTRY_W +: ENTRY_W].
   typedef logic [MAX_NOTES*ENTRY_W-1:0] melody_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
`ifdef CHIME_GAP_EN
      S_GAP,
`endif
      S_DONE
   } state_e;

   function automatic int note_hz(input int code);
      case (code)
         1:       return 82;
         2:       return 92;
         3:       return 262;
         4:       return 277;
         5:       return 294;
         6:       return 311;
         7:       return 330;
         8:       return 349;
         9:       return 370;
         10:      return 392;
         11:      return 415;
         12:      return 440;
         13:      return 466;
         14:      return 494;
         default: return 0;
      endcase
   endfunction

   // Only ever called with constant arguments, so the division folds away at elaboration.
   function automatic int half_period_of(input int clk_freq, input int code);
      int hz;
      hz = note_hz(code);
      return (hz == 0) ? 0 : clk_freq / (2 * hz);
   endfunction

   localparam entry_t DEFAULT_TABLE [17] = '{
      '{E4, 16'd400},  '{GS4, 16'd400}, '{FS4, 16'd400}, '{B4, 16'd800},
      '{REST, 16'd200}, '{E4, 16'd400}, '{FS4, 16'd400}, '{GS4, 16'd400},
      '{E4, 16'd800},  '{REST, 16'd200}, '{GS4, 16'd400}, '{E4, 16'd400},
      '{FS4, 16'd400}, '{B4, 16'd800},  '{REST, 16'd400}, '{E2, 16'd1200},
      '{FS2, 16'd1200}
   };

   function automatic melody_t pack_default();
      melody_t m;
      m = '0;
      for (int i = 0; i < 17; i++) m[i*ENTRY_W +: ENTRY_W] = DEFAULT_TABLE[i];
      return m;
   endfunction

   localparam melody_t DEFAULT_MELODY = pack_default();

endpackage

// File: rtl/chime_sequencer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CYCLES_PER_MS clocks, restarted by a synchronous clear.
module ms_tick_gen #(
   parameter int CYCLES_PER_MS = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_MS - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = !clear && (cnt == LAST);

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register regardless of evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          cnt <= '0;
      else if (clear || tick) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/chime_sequencer.sv
// Melody sequencer feeding the PWM tone generator; steps a constant note table on start.
// Define CHIME_GAP_EN to insert a GAP_MS silence between consecutive notes.
module chime_sequencer
   import chime_pkg::*;
#(
   parameter int      CLK_FREQ  = 50000000,
   parameter int      NUM_NOTES = 17,
   parameter int      DUR_W     = 16,
   parameter int      HP_W      = 26,
   parameter melody_t MELODY    = DEFAULT_MELODY
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      repeat_cnt,
   input  logic            abort,
   output logic [HP_W-1:0] half_period,
   output logic            tone_en,
   output logic [4:0]      note_idx,
   output logic            busy,
   output logic            done
);

   localparam int         CYC_PER_MS = CLK_FREQ / 1000;
   localparam logic [4:0] LAST_IDX   = 5'(NUM_NOTES - 1);

   state_e           state, state_n;
   logic [4:0]       idx_n, adv_idx;
   logic [2:0]       rep_left, rep_n, adv_rep;
   logic [DUR_W-1:0] dur_cnt;
   logic             tick, end_tick, is_final;
   logic             enter_load, enter_gap;
   logic [HP_W-1:0]  hp_lut [NUM_CODES];

   for (genvar c = 0; c < NUM_CODES; c++) begin : g_hp
      assign hp_lut[c] = HP_W'(half_period_of(CLK_FREQ, c));
   end

   function automatic entry_t entry_at(input logic [4:0] idx);
      return entry_t'(MELODY[int'(idx)*ENTRY_W +: ENTRY_W]);
   endfunction

   // Codes beyond the defined set behave as REST.
   function automatic logic code_valid(input note_e code);
      return (int'(code) < NUM_CODES) && (code != REST);
   endfunction

   function automatic logic [HP_W-1:0] code_hp(input note_e code);
      return code_valid(code) ? hp_lut[code[3:0]] : '0;
   endfunction

   function automatic logic [DUR_W-1:0] dur_of(input entry_t e);
      return (e.dur_ms == '0) ? DUR_W'(1) : DUR_W'(e.dur_ms);
   endfunction

   ms_tick_gen #(.CYCLES_PER_MS(CYC_PER_MS)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef CHIME_GAP_EN
      .clear   (!(state == S_PLAY || state == S_GAP)),
`else
      .clear   (state != S_PLAY),
`endif
      .tick    (tick)
   );

   assign end_tick = tick && (dur_cnt == DUR_W'(1));
   assign is_final = (note_idx == LAST_IDX) && (rep_left == 3'd0);
   assign adv_idx  = (note_idx == LAST_IDX) ? 5'd0 : note_idx + 5'd1;
   assign adv_rep  = (note_idx == LAST_IDX) ? rep_left - 3'd1 : rep_left;

   // NOTE: every always_comb output gets a default before the case so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_n    = state;
      idx_n      = note_idx;
      rep_n      = rep_left;
      enter_load = 1'b0;
      enter_gap  = 1'b0;
      case (state)
         S_IDLE: if (start && !abort) begin
            state_n    = S_LOAD;
            idx_n      = 5'd0;
            rep_n      = repeat_cnt;
            enter_load = 1'b1;
         end
         S_LOAD: state_n = S_PLAY;
         S_PLAY: if (end_tick) begin
            if (is_final) begin
               state_n = S_DONE;
            end else begin
`ifdef CHIME_GAP_EN
               state_n   = S_GAP;
               enter_gap = 1'b1;
`else
               state_n    = S_LOAD;
               idx_n      = adv_idx;
               rep_n      = adv_rep;
               enter_load = 1'b1;
`endif
            end
         end
`ifdef CHIME_GAP_EN
         S_GAP: if (end_tick) begin
            state_n    = S_LOAD;
            idx_n      = adv_idx;
            rep_n      = adv_rep;
            enter_load = 1'b1;
         end
`endif
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         state_n    = S_IDLE;
         enter_load = 1'b0;
         enter_gap  = 1'b0;
      end
   end

   // Tone outputs are loaded on the edge into LOAD so they cover the LOAD cycle too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         note_idx    <= '0;
         rep_left    <= '0;
         dur_cnt     <= '0;
         half_period <= '0;
         tone_en     <= 1'b0;
      end else begin
         state    <= state_n;
         note_idx <= idx_n;
         rep_left <= rep_n;
         if (enter_load) begin
            half_period <= code_hp(entry_at(idx_n).code);
            tone_en     <= code_valid(entry_at(idx_n).code);
         end else if (enter_gap) begin
            tone_en <= 1'b0;
         end else if (state_n == S_IDLE || state_n == S_DONE) begin
            half_period <= '0;
            tone_en     <= 1'b0;
         end
         if (state == S_LOAD)  dur_cnt <= dur_of(entry_at(note_idx));
         else if (enter_gap)   dur_cnt <= DUR_W'(GAP_MS);
         else if (tick)        dur_cnt <= dur_cnt - DUR_W'(1);
      end
   end

   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer with a 3-note table at 10 cycles/ms.
module tb_chime_sequencer;
   import chime_pkg::*;

   localparam int CLK_FREQ = 10000;
   localparam int CPM      = CLK_FREQ / 1000;
   localparam int NN       = 3;
   localparam int HP_W     = 26;
`ifdef CHIME_GAP_EN
   localparam int GAP_CYC = 20 * CPM;
`else
   localparam int GAP_CYC = 0;
`endif

   localparam note_e TB_CODE [NN] = '{A4, REST, C4};
   localparam int    TB_DUR  [NN] = '{2, 1, 0};
   localparam int    TB_HZ   [NN] = '{440, 0, 262};

   function automatic melody_t build_melody();
      melody_t m;
      m = '0;
      for (int i = 0; i < NN; i++) m[i*ENTRY_W +: ENTRY_W] = {TB_CODE[i], 16'(TB_DUR[i])};
      return m;
   endfunction

   localparam melody_t TB_MELODY = build_melody();

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic [2:0]      repeat_cnt = '0;
   logic            abort = 1'b0;
   logic [HP_W-1:0] half_period;
   logic            tone_en;
   logic [4:0]      note_idx;
   logic            busy;
   logic            done;

   chime_sequencer #(
      .CLK_FREQ(CLK_FREQ), .NUM_NOTES(NN), .DUR_W(16), .HP_W(HP_W), .MELODY(TB_MELODY)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
      .half_period(half_period), .tone_en(tone_en), .note_idx(note_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [HP_W-1:0] hp;
      logic            en;
      logic [4:0]      idx;
      logic            busy;
      logic            done;
   } obs_t;

   typedef struct {
      int rep;
      int abort_at;
      int extra_start;
      int exp_busy;
      int exp_done;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pass_cycles();
      int t = 0;
      for (int n = 0; n < NN; n++) t += 1 + ((TB_DUR[n] == 0) ? 1 : TB_DUR[n]) * CPM;
      return t + (NN - 1) * GAP_CYC;
   endfunction

   function automatic int total_busy(input int rep);
      return (rep + 1) * pass_cycles() + rep * GAP_CYC;
   endfunction

   // Reference schedule: one record per clock from the first LOAD through the done pulse.
   task automatic build_expected(input int rep);
      obs_t o;
      exp_q.delete();
      for (int p = 0; p <= rep; p++) begin
         for (int n = 0; n < NN; n++) begin
            int ms = (TB_DUR[n] == 0) ? 1 : TB_DUR[n];
            o.hp   = (TB_HZ[n] == 0) ? '0 : HP_W'(CLK_FREQ / (2 * TB_HZ[n]));
            o.en   = (TB_HZ[n] != 0);
            o.idx  = 5'(n);
            o.busy = 1'b1;
            o.done = 1'b0;
            for (int c = 0; c < 1 + ms * CPM; c++) exp_q.push_back(o);
            if (!(p == rep && n == NN - 1)) begin
               o.en = 1'b0;
               for (int c = 0; c < GAP_CYC; c++) exp_q.push_back(o);
            end
         end
      end
      o = '{hp: '0, en: 1'b0, idx: '0, busy: 1'b0, done: 1'b1};
      exp_q.push_back(o);
   endtask

   task automatic compare_obs(input string tag, input obs_t e);
      check({tag, ".half_period"}, 32'(half_period), 32'(e.hp));
      check({tag, ".tone_en"}, 32'(tone_en), 32'(e.en));
      check({tag, ".busy"}, 32'(busy), 32'(e.busy));
      check({tag, ".done"}, 32'(done), 32'(e.done));
      if (e.busy) check({tag, ".note_idx"}, 32'(note_idx), 32'(e.idx));
   endtask

   task automatic check_idle(input string tag);
      obs_t idle;
      idle = '{hp: '0, en: 1'b0, idx: '0, busy: 1'b0, done: 1'b0};
      compare_obs(tag, idle);
   endtask

   // Inputs change on the falling edge, outputs are sampled there before the change.
   task automatic run_play(input string tag, input int rep, input int abort_at, input int extra_at,
                           output int busy_cyc, output int done_cnt);
      busy_cyc = 0;
      done_cnt = 0;
      build_expected(rep);
      @(negedge clk);
      start = 1'b1;
      repeat_cnt = 3'(rep);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         compare_obs($sformatf("%s.c%0d", tag, i), exp_q[i]);
         busy_cyc += int'(busy);
         done_cnt += int'(done);
         if (i == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check_idle($sformatf("%s.post_abort", tag));
            done_cnt += int'(done);
            break;
         end
         start = (i == extra_at);
         @(negedge clk);
      end
      start = 1'b0;
      check_idle({tag, ".end_idle"});
      done_cnt += int'(done);
   endtask

   vec_t vecs [5];

   initial begin
      int bc, dc, total;
      vecs[0] = '{rep: 0, abort_at: -1, extra_start: -1, exp_busy: total_busy(0), exp_done: 1};
      vecs[1] = '{rep: 2, abort_at: -1, extra_start: -1, exp_busy: total_busy(2), exp_done: 1};
      vecs[2] = '{rep: 0, abort_at: 5, extra_start: 2, exp_busy: 6, exp_done: 0};
      vecs[3] = '{rep: 0, abort_at: -1, extra_start: 30, exp_busy: total_busy(0), exp_done: 1};
      vecs[4] = '{rep: 1, abort_at: 25, extra_start: -1, exp_busy: 26, exp_done: 0};

      repeat (3) @(negedge clk);
      check_idle("in_reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("after_reset");
      check("after_reset.note_idx", 32'(note_idx), 32'd0);

      for (int v = 0; v < 5; v++) begin
         run_play($sformatf("vec%0d", v), vecs[v].rep, vecs[v].abort_at, vecs[v].extra_start, bc, dc);
         check($sformatf("vec%0d.busy_cycles", v), 32'(bc), 32'(vecs[v].exp_busy));
         check($sformatf("vec%0d.done_pulses", v), 32'(dc), 32'(vecs[v].exp_done));
      end

      // Start and abort together from IDLE: abort wins.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle($sformatf("start_abort.c%0d", i));
         @(negedge clk);
      end

      for (int r = 0; r < 6; r++) begin
         int rep, ab, ex;
         rep   = $urandom_range(0, 3);
         total = total_busy(rep);
         ab    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
         ex    = int'($urandom_range(0, total - 1));
         run_play($sformatf("rnd%0d", r), rep, ab, ex, bc, dc);
         check($sformatf("rnd%0d.busy_cycles", r), 32'(bc), 32'((ab < 0) ? total : ab + 1));
         check($sformatf("rnd%0d.done_pulses", r), 32'(dc), 32'((ab < 0) ? 1 : 0));
      end

      // Asynchronous reset in the middle of note 0.
      @(negedge clk);
      start = 1'b1;
      repeat_cnt = 3'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_reset.tone_en", 32'(tone_en), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("post_async_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
